argmax_readout: RTL and testbench

Result-side consumer of the fully-connected classifier. It captures the `NUM_CLASSES` signed logits presented with the network's `done` pulse and scans them serially, one per cycle. It then returns the winning class index, its logit and the margin over the runner-up through a valid/ready handshake. It sits directly downstream of `top_fc` and replaces the bench-side argmax in integrated builds.

---
 rtl/fc_pkg.sv | 19 +
 rtl/argmax_update.sv | 46 ++++
 rtl/argmax_readout.sv | 143 ++++++++++++++
 tb/tb_argmax_readout.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected classifier
// and its result-side consumers.
package fc_pkg;

  localparam int DATA_W      = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  typedef logic signed [DATA_W-1:0] logit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD
  } state_e;

  localparam logit_t LOGIT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/argmax_update.sv
// One argmax step: folds logit i into the running
// (max, second, idx) triple. Index 0 seeds the triple.
module argmax_update
  import fc_pkg::*;
#(
  parameter int DATA_W = fc_pkg::DATA_W,
  parameter int IDX_W  = fc_pkg::IDX_W
) (
  input  logic signed [DATA_W-1:0] max_in,
  input  logic signed [DATA_W-1:0] sec_in,
  input  logic        [IDX_W-1:0]  idx_in,
  input  logic signed [DATA_W-1:0] l_in,
  input  logic        [IDX_W-1:0]  i_in,
  output logic signed [DATA_W-1:0] max_out,
  output logic signed [DATA_W-1:0] sec_out,
  output logic        [IDX_W-1:0]  idx_out
);

  localparam logic signed [DATA_W-1:0] MIN_V =
    {1'b1, {(DATA_W-1){1'b0}}};

  // Strict compare keeps the lowest index on ties; an equal
  // logit still becomes the runner-up.
  always_comb begin
    max_out = max_in;
    sec_out = sec_in;
    idx_out = idx_in;
    priority case (1'b1)
      (i_in == '0): begin
        max_out = l_in;
        sec_out = MIN_V;
        idx_out = '0;
      end
      (l_in > max_in): begin
        sec_out = max_in;
        max_out = l_in;
        idx_out = i_in;
      end
      (l_in > sec_in): begin
        sec_out = l_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/argmax_readout.sv
// Serial argmax over captured classifier logits with a
// valid/ready result port and a sticky overrun flag.
module argmax_readout
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = fc_pkg::NUM_CLASSES,
  parameter int DATA_W      = fc_pkg::DATA_W,
  parameter int IDX_W       = fc_pkg::IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done_in,
  input  logic [NUM_CLASSES*DATA_W-1:0] logits_in,
  output logic                          busy,
  output logic                          pred_valid,
  input  logic                          pred_ready,
  output logic [IDX_W-1:0]              pred_idx,
  output logic [DATA_W-1:0]             pred_val,
  output logic [DATA_W:0]               pred_margin,
  output logic                          overrun
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES-1);

  state_e state_q, state_d;

  logic [NUM_CLASSES*DATA_W-1:0] lg_q, lg_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  pidx_q, pidx_d;
  logic [DATA_W-1:0] pval_q, pval_d;
  logic [DATA_W:0]   pmar_q, pmar_d;
  logic              ovr_q, ovr_d;

  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [DATA_W-1:0] sec_q, sec_d;
  logic signed [DATA_W-1:0] l_cur;
  logic signed [DATA_W-1:0] upd_max, upd_sec;
  logic        [IDX_W-1:0]  upd_idx;

  assign l_cur = lg_q[int'(cnt_q)*DATA_W +: DATA_W];

  argmax_update #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_upd (
    .max_in  (max_q),
    .sec_in  (sec_q),
    .idx_in  (idx_q),
    .l_in    (l_cur),
    .i_in    (cnt_q),
    .max_out (upd_max),
    .sec_out (upd_sec),
    .idx_out (upd_idx)
  );

  // Next-state: capture, serial scan, result hold/handshake.
  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    sec_d   = sec_q;
    idx_d   = idx_q;
    pidx_d  = pidx_q;
    pval_d  = pval_q;
    pmar_d  = pmar_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (done_in) begin
          lg_d    = logits_in;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        max_d = upd_max;
        sec_d = upd_sec;
        idx_d = upd_idx;
        if (done_in) ovr_d = 1'b1;
        if (cnt_q == LAST) begin
          pidx_d  = upd_idx;
          pval_d  = upd_max;
          pmar_d  = {upd_max[DATA_W-1], upd_max}
                  - {upd_sec[DATA_W-1], upd_sec};
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (pred_ready) begin
          if (done_in) begin
            lg_d    = logits_in;
            cnt_d   = '0;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (done_in) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lg_q    <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      sec_q   <= '0;
      idx_q   <= '0;
      pidx_q  <= '0;
      pval_q  <= '0;
      pmar_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      sec_q   <= sec_d;
      idx_q   <= idx_d;
      pidx_q  <= pidx_d;
      pval_q  <= pval_d;
      pmar_q  <= pmar_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign pred_valid  = (state_q == ST_HOLD);
  assign pred_idx    = pidx_q;
  assign pred_val    = pval_q;
  assign pred_margin = pmar_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_argmax_readout.sv
// Bench for argmax_readout: table vectors, random
// stimulus against a reference model, handshake corners.
module tb_argmax_readout;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           done_in;
  logic [N*W-1:0] logits_in;
  logic           busy;
  logic           pred_valid;
  logic           pred_ready;
  logic [IW-1:0]  pred_idx;
  logic [W-1:0]   pred_val;
  logic [W:0]     pred_margin;
  logic           overrun;

  argmax_readout dut (
    .clk         (clk),
    .rst         (rst),
    .done_in     (done_in),
    .logits_in   (logits_in),
    .busy        (busy),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_idx    (pred_idx),
    .pred_val    (pred_val),
    .pred_margin (pred_margin),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [N*W-1:0] lg;
    logic [IW-1:0]  idx;
    logic [W-1:0]   val;
    logic [W:0]     mar;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(
    input logic [W-1:0] a [N]);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  // Reference: winner is the first maximum, runner-up the
  // largest of the remaining logits (multiset second max).
  task automatic model(input  logic [N*W-1:0] lg,
                       output logic [IW-1:0]  idx,
                       output logic [W-1:0]   val,
                       output logic [W:0]     mar);
    int v [N];
    int best;
    int sec;
    for (int i = 0; i < N; i++)
      v[i] = int'($signed(lg[i*W +: W]));
    best = 0;
    for (int i = 1; i < N; i++)
      if (v[i] > v[best]) best = i;
    sec = -(1 << (W-1));
    for (int i = 0; i < N; i++)
      if (i != best && v[i] > sec) sec = v[i];
    idx = IW'(best);
    val = W'(v[best]);
    mar = (W+1)'(v[best] - sec);
  endtask

  function automatic logic [N*W-1:0] rand_lg(input int mode);
    logic [N*W-1:0] r;
    logic [W-1:0] ext [4];
    ext = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: r[i*W +: W] = W'($urandom);
        1: r[i*W +: W] = W'($urandom_range(0, 3));
        default: r[i*W +: W] = ext[$urandom_range(0, 3)];
      endcase
    end
    return r;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    done_in    = 1'b0;
    pred_ready = 1'b0;
    logits_in  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse done_in over one posedge; returns at the negedge
  // after the capture edge with logits_in scrambled.
  task automatic start(input logic [N*W-1:0] lg);
    @(negedge clk);
    done_in   = 1'b1;
    logits_in = lg;
    @(negedge clk);
    done_in   = 1'b0;
    logits_in = rand_lg(0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!pred_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("valid_seen", 32'(pred_valid), 32'd1);
  endtask

  task automatic accept();
    pred_ready = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
  endtask

  task automatic check_res(input string name,
                           input logic [IW-1:0] ei,
                           input logic [W-1:0]  ev,
                           input logic [W:0]    em);
    check({name, "_idx"}, 32'(pred_idx), 32'(ei));
    check({name, "_val"}, 32'(pred_val), 32'(ev));
    check({name, "_mar"}, 32'(pred_margin), 32'(em));
  endtask

  initial begin
    logic [W-1:0]   t [N];
    logic [IW-1:0]  ei;
    logic [W-1:0]   ev;
    logic [W:0]     em;
    logic [N*W-1:0] lb;
    int lat;
    int bad;

    t = '{16'h0005, 16'hFFFD, 16'h0010, 16'h0000, 16'h0200,
          16'h0007, 16'hFFFF, 16'h0400, 16'h03F0, 16'h0002};
    vecs[0] = '{pack(t), 4'd7, 16'h0400, 17'h00010};
    t = '{16'hFFFF, 16'hFFFE, 16'h0100, 16'h8000, 16'hFFF0,
          16'h0100, 16'hFFFF, 16'h8001, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{pack(t), 4'd2, 16'h0100, 17'h00000};
    for (int i = 0; i < N; i++) t[i] = 16'h8000;
    vecs[2] = '{pack(t), 4'd0, 16'h8000, 17'h00000};
    t[3] = 16'h7FFF;
    vecs[3] = '{pack(t), 4'd3, 16'h7FFF, 17'h0FFFF};
    for (int i = 0; i < N; i++) t[i] = W'(i);
    vecs[4] = '{pack(t), 4'd9, 16'h0009, 17'h00001};

    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(pred_valid), 32'd0);
    check("rst_idx", 32'(pred_idx), 32'd0);
    check("rst_val", 32'(pred_val), 32'd0);
    check("rst_mar", 32'(pred_margin), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // Table vectors with pred_ready held high.
    pred_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      start(vecs[v].lg);
      check($sformatf("tbl%0d_busy", v), 32'(busy), 32'd1);
      wait_valid(lat);
      check($sformatf("tbl%0d_lat", v), lat, 32'd10);
      check_res($sformatf("tbl%0d", v),
                vecs[v].idx, vecs[v].val, vecs[v].mar);
      @(negedge clk);
      check($sformatf("tbl%0d_vfall", v),
            32'(pred_valid), 32'd0);
      check($sformatf("tbl%0d_idle", v), 32'(busy), 32'd0);
    end

    // Random stimulus against the reference model.
    for (int r = 0; r < 40; r++) begin
      lb = rand_lg(r % 3);
      model(lb, ei, ev, em);
      start(lb);
      wait_valid(lat);
      check($sformatf("rnd%0d_lat", r), lat, 32'd10);
      check_res($sformatf("rnd%0d", r), ei, ev, em);
      @(negedge clk);
    end
    check("rnd_ovr", 32'(overrun), 32'd0);

    // Backpressure with a dropped done_in during HOLD.
    pred_ready = 1'b0;
    start(vecs[0].lg);
    wait_valid(lat);
    check("bp_lat", lat, 32'd10);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      done_in = (c == 8);
      if (c == 8) logits_in = rand_lg(0);
      @(negedge clk);
      if (!pred_valid || pred_idx !== vecs[0].idx ||
          pred_val !== vecs[0].val ||
          pred_margin !== vecs[0].mar) bad++;
    end
    done_in = 1'b0;
    check("bp_stable_bad", bad, 32'd0);
    check("bp_ovr", 32'(overrun), 32'd1);
    accept();
    check("bp_vfall", 32'(pred_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    check("bp_ovr_clr", 32'(overrun), 32'd0);

    // Reset mid-scan after leaving a result and overrun set.
    pred_ready = 1'b1;
    start(vecs[0].lg);
    wait_valid(lat);
    @(negedge clk);
    start(vecs[1].lg);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    repeat (2) @(negedge clk);
    check("ms_ovr_pre", 32'(overrun), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("ms_busy", 32'(busy), 32'd0);
    check("ms_valid", 32'(pred_valid), 32'd0);
    check("ms_idx", 32'(pred_idx), 32'd0);
    check("ms_val", 32'(pred_val), 32'd0);
    check("ms_mar", 32'(pred_margin), 32'd0);
    check("ms_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start(vecs[3].lg);
    wait_valid(lat);
    check("ms_lat", lat, 32'd10);
    check_res("ms", vecs[3].idx, vecs[3].val, vecs[3].mar);
    check("ms_ovr_after", 32'(overrun), 32'd0);
    @(negedge clk);

    // Back-to-back: done_in on the handshake edge.
    pred_ready = 1'b0;
    start(vecs[0].lg);
    wait_valid(lat);
    lb = rand_lg(0);
    model(lb, ei, ev, em);
    pred_ready = 1'b1;
    done_in    = 1'b1;
    logits_in  = lb;
    @(negedge clk);
    pred_ready = 1'b0;
    done_in    = 1'b0;
    logits_in  = rand_lg(0);
    check("b2b_vlow", 32'(pred_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    check("b2b_low_cycles", lat, 32'd10);
    check_res("b2b", ei, ev, em);
    check("b2b_ovr", 32'(overrun), 32'd0);
    accept();

    // Overrun during scan leaves the first result intact.
    start(vecs[4].lg);
    repeat (2) @(negedge clk);
    done_in   = 1'b1;
    logits_in = vecs[0].lg;
    @(negedge clk);
    done_in = 1'b0;
    wait_valid(lat);
    check_res("osc", vecs[4].idx, vecs[4].val, vecs[4].mar);
    check("osc_ovr", 32'(overrun), 32'd1);
    accept();
    repeat (5) @(negedge clk);
    check("osc_ovr_sticky", 32'(overrun), 32'd1);
    check("osc_idle", 32'(busy), 32'd0);
    do_reset();
    check("osc_ovr_clr", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
